// File: rtl/prog_timer.sv
// Programmable MM:SS count-down timer / count-up stopwatch with BCD display outputs.
// Optional expiry alarm blinker is enabled by defining PROG_TIMER_ALARM_EN.
module prog_timer #(
    parameter int CLK_DIV = 100000000,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       tmrreset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       mode,
    input  logic       inc_sec,
    input  logic       inc_min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic [1:0] fsm_state
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state_q, state_d;
    logic [5:0]    sec_q, sec_d, sec_inc;
    logic [6:0]    min_q, min_d, min_inc;
    logic [PW-1:0] pre_q, pre_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic          alarm_q, alarm_d;
    logic          tick;

    always_ff @(posedge clk or negedge tmrreset_n) begin
        if (!tmrreset_n) begin
            state_q <= IDLE;
            sec_q   <= '0;
            min_q   <= '0;
            pre_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    // Wrapping increments shared by the set buttons and the count-up tick.
    assign sec_inc = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    assign min_inc = (min_q == MIN_TOP) ? 7'd0 : min_q + 7'd1;
    assign tick    = (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        alarm_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            sec_d   = '0;
            min_d   = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop) begin
                        if (start) begin
                            if (mode || sec_q != 6'd0 || min_q != 7'd0) begin
                                mode_d  = mode;
                                pre_d   = '0;
                                state_d = RUN;
                            end
                        end else begin
                            if (inc_sec) sec_d = sec_inc;
                            if (inc_min) min_d = min_inc;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (mode_q) begin
                            if (sec_q != 6'd59) begin
                                sec_d = sec_inc;
                            end else begin
                                sec_d = '0;
                                min_d = min_inc;
                            end
                            if (min_q == MIN_TOP && sec_q == 6'd58) state_d = EXPIRED;
                        end else begin
                            if (sec_q != 6'd0) begin
                                sec_d = sec_q - 6'd1;
                            end else if (min_q != 7'd0) begin
                                min_d = min_q - 7'd1;
                                sec_d = 6'd59;
                            end
                            if (min_q == 7'd0 && sec_q <= 6'd1) state_d = EXPIRED;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!stop) begin
                        if (start) begin
                            state_d = RUN;
                        end else begin
                            if (inc_sec) sec_d = sec_inc;
                            if (inc_min) min_d = min_inc;
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        state_d = IDLE;
                        pre_d   = '0;
                    end else begin
`ifdef PROG_TIMER_ALARM_EN
                        // Prescaler keeps ticking here purely to pace the alarm blink.
                        alarm_d = tick ? ~alarm_q : alarm_q;
                        pre_d   = tick ? '0 : pre_q + 1'b1;
`endif
                    end
                end
            endcase
        end
`ifdef PROG_TIMER_ALARM_EN
        if (state_d == EXPIRED && state_q != EXPIRED) alarm_d = 1'b1;
`endif
    end

    assign done_d = (state_d == EXPIRED) && (state_q != EXPIRED);

    assign sec_tens  = 4'(sec_q / 6'd10);
    assign sec_ones  = 4'(sec_q % 6'd10);
    assign min_tens  = 4'(min_q / 7'd10);
    assign min_ones  = 4'(min_q % 7'd10);
    assign running   = (state_q == RUN);
    assign done      = done_q;
    assign alarm     = alarm_q;
    assign fsm_state = state_q;
endmodule

// File: tb/tb_prog_timer.sv
// Randomized and directed bench for prog_timer (CLK_DIV=4, MIN_MAX=2) against a
// seconds-based reference model; expected outputs are queued and checked by a monitor.
module tb_prog_timer;
    localparam int CLK_DIV = 4;
    localparam int MIN_MAX = 2;
    localparam int LIMIT   = MIN_MAX * 60 + 59;
    localparam int SPAN    = (MIN_MAX + 1) * 60;
`ifdef PROG_TIMER_ALARM_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       tmrreset_n, start, stop, clear, mode, inc_sec, inc_min;
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
    logic       running, done, alarm;
    logic [1:0] fsm_state;
    logic [18:0] got;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    prog_timer #(.CLK_DIV(CLK_DIV), .MIN_MAX(MIN_MAX)) dut (
        .clk(clk), .tmrreset_n(tmrreset_n), .start(start), .stop(stop),
        .clear(clear), .mode(mode), .inc_sec(inc_sec), .inc_min(inc_min),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .min_tens(min_tens),
        .min_ones(min_ones), .running(running), .done(done), .alarm(alarm),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign got = {sec_tens, sec_ones, min_tens, min_ones, running, done, alarm};

    // Reference model: time held as total seconds, behaviour from the block's rules.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
    mstate_t ms;
    int      t, pre;
    bit      m_mode, m_done, m_alarm;

    function automatic logic [15:0] bcd_of(input int m, input int s);
        return {4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [18:0] model_out();
        return {bcd_of(t / 60, t % 60), ms == M_RUN, m_done, m_alarm};
    endfunction

    task automatic model_reset();
        ms = M_IDLE; t = 0; pre = 0; m_mode = 0; m_done = 0; m_alarm = 0;
    endtask

    task automatic model_set(input bit is, input bit im);
        int s, m;
        s = t % 60;
        m = t / 60;
        if (is) s = (s == 59) ? 0 : s + 1;
        if (im) m = (m == MIN_MAX) ? 0 : m + 1;
        t = m * 60 + s;
    endtask

    task automatic model_step(input bit c, input bit sp, input bit st,
                              input bit is, input bit im, input bit md);
        mstate_t prev = ms;
        bit blink = 0;
        if (c) begin
            ms = M_IDLE; t = 0; pre = 0;
        end else begin
            case (ms)
                M_IDLE: if (!sp) begin
                    if (st) begin
                        if (md || t != 0) begin m_mode = md; pre = 0; ms = M_RUN; end
                    end else model_set(is, im);
                end
                M_RUN: if (sp) ms = M_PAUSE;
                else if (pre == CLK_DIV - 1) begin
                    pre = 0;
                    if (m_mode) begin
                        t = (t + 1) % SPAN;
                        if (t == LIMIT) ms = M_EXP;
                    end else begin
                        t = (t == 0) ? 0 : t - 1;
                        if (t == 0) ms = M_EXP;
                    end
                end else pre++;
                M_PAUSE: if (!sp) begin
                    if (st) ms = M_RUN;
                    else model_set(is, im);
                end
                default: if (sp) begin
                    ms = M_IDLE; pre = 0;
                end else if (AL) begin
                    if (pre == CLK_DIV - 1) begin pre = 0; blink = 1; end
                    else pre++;
                end
            endcase
        end
        m_done = (ms == M_EXP) && (prev != M_EXP);
        if (ms != M_EXP || !AL) m_alarm = 0;
        else if (prev != M_EXP) m_alarm = 1;
        else if (blink) m_alarm = ~m_alarm;
    endtask

    task automatic step(input bit c, input bit sp, input bit st,
                        input bit is, input bit im, input bit md);
        @(negedge clk);
        clear = c; stop = sp; start = st; inc_sec = is; inc_min = im; mode = md;
        model_step(c, sp, st, is, im, md);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, g, e);
        end
    endtask

    // Monitor: every edge the DUT presents fresh outputs; compare against the queue.
    always @(posedge clk) begin
        logic [18:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, got, e);
            end
        end
    end

    initial begin
        tmrreset_n = 0; clear = 0; stop = 0; start = 0; mode = 0; inc_sec = 0; inc_min = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs", 32'(got), 32'd0);
        check_val("reset_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        tmrreset_n = 1;

        // Reset in the middle of a count at 01:30.
        step(0, 0, 0, 0, 1, 0);
        repeat (30) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        peek();
        check_val("run_at_0130", 32'(got), 32'({bcd_of(1, 30), 3'b100}));
        #1;
        tmrreset_n = 0;
        #1;
        check_val("async_reset_outputs", 32'(got), 32'd0);
        check_val("async_reset_state", 32'(fsm_state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        tmrreset_n = 1;
        model_reset();
        idle(6);
        peek();
        check_val("idle_after_reset", 32'(got), 32'd0);

        // Count down from 01:02.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(4);
        peek();
        check_val("cd_first_tick", 32'(got[18:3]), 32'(bcd_of(1, 1)));
        idle(244);
        peek();
        check_val("cd_expired", 32'(got), 32'({bcd_of(0, 0), 2'b01, AL}));
        idle(4);
        peek();
        check_val("cd_done_once_alarm_low", 32'(got[1:0]), 32'd0);
        idle(4);
        peek();
        check_val("cd_alarm_again", 32'(got[0]), 32'(AL));
        step(0, 1, 0, 0, 0, 0);
        peek();
        check_val("cd_stop_idle", 32'(got), 32'd0);

        // Count up from 00:00 to MIN_MAX:59.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        idle(716);
        peek();
        check_val("cu_expired", 32'(got[18:1]), 32'({bcd_of(2, 59), 2'b01}));
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        peek();
        check_val("cu_stop_keeps_time", 32'(got), 32'({bcd_of(2, 59), 3'b000}));

        // Pause with prescaler at 2, adjust, resume.
        step(1, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 1, 0, 0, 0, 0);
        idle(20);
        step(0, 0, 0, 1, 0, 0);
        peek();
        check_val("pause_inc", 32'(got), 32'({bcd_of(0, 11), 3'b000}));
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        peek();
        check_val("resume_tick", 32'(got), 32'({bcd_of(0, 10), 3'b100}));

        // clear beats stop and start; seconds wrap; count-down start at zero ignored.
        step(1, 1, 1, 0, 0, 0);
        peek();
        check_val("clear_priority", 32'(got), 32'd0);
        repeat (59) step(0, 0, 0, 1, 0, 0);
        peek();
        check_val("sec_59", 32'(got[18:3]), 32'(bcd_of(0, 59)));
        step(0, 0, 0, 1, 0, 0);
        peek();
        check_val("sec_wrap", 32'(got[18:3]), 32'(bcd_of(0, 0)));
        step(0, 0, 1, 0, 0, 0);
        peek();
        check_val("zero_start_ignored", 32'(got[2]), 32'd0);

        // Random single-pulse stimulus.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit md;
            r  = int'($urandom_range(0, 99));
            md = 1'($urandom_range(0, 1));
            if (r < 2)       step(1, 0, 0, 0, 0, md);
            else if (r < 6)  step(0, 1, 0, 0, 0, md);
            else if (r < 12) step(0, 0, 1, 0, 0, md);
            else if (r < 20) step(0, 0, 0, 1, 0, md);
            else if (r < 26) step(0, 0, 0, 0, 1, md);
            else             step(0, 0, 0, 0, 0, md);
        end
        idle(1);
        peek();
        @(posedge clk);
        #3;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
